// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for an output-stationary ROWS x COLS MAC array: clear, stream K
// activation/weight vectors with skewed lane valids, drain, then capture and done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; K and base addresses latched on accept
// CLEAR   | one-cycle accumulator clear pulse to the array
// FEED    | K cycles of activation/weight reads, addresses step by one
// DRAIN   | ROWS+COLS+1 cycles for the skewed wavefront to leave the array
// CAPTURE | one-cycle capture pulse; array outputs are final
// DONE    | one-cycle done pulse (with err when K was zero)
module systolic_tile_ctrl #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int KW   = 8,
   parameter int AW   = 10
) (
   input  logic            i_clock,
   input  logic            i_reset_n,
   input  logic            i_start,
   input  logic            i_abort,
   input  logic [KW-1:0]   i_k_len,
   input  logic [AW-1:0]   i_a_base,
   input  logic [AW-1:0]   i_w_base,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_err,
   output logic            o_pe_clear,
   output logic            o_a_rd_en,
   output logic [AW-1:0]   o_a_rd_addr,
   output logic            o_w_rd_en,
   output logic [AW-1:0]   o_w_rd_addr,
   output logic [ROWS-1:0] o_row_valid,
   output logic [COLS-1:0] o_col_valid,
   output logic            o_capture
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_CAPTURE, S_DONE
   } state_t;

   // One down-counter serves both FEED (K reads) and DRAIN, so size it for the larger.
   localparam int DW = $clog2(ROWS + COLS + 2);
   localparam int CW = (KW > DW) ? KW : DW;
   localparam logic [CW-1:0] DRAIN_LEN = CW'(ROWS + COLS + 1);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [AW-1:0]   a_base, a_base_nx, w_base, w_base_nx;
   logic [AW-1:0]   a_addr_nx, w_addr_nx;
   logic            busy_nx, done_nx, err_nx, clear_nx, rd_en_nx, capture_nx;
   logic            flush;

   assign flush = i_abort && (state != S_IDLE);

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      a_base_nx  = a_base;
      w_base_nx  = w_base;
      a_addr_nx  = o_a_rd_addr;
      w_addr_nx  = o_w_rd_addr;
      busy_nx    = 1'b0;
      done_nx    = 1'b0;
      err_nx     = 1'b0;
      clear_nx   = 1'b0;
      rd_en_nx   = 1'b0;
      capture_nx = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               a_base_nx = i_a_base;
               w_base_nx = i_w_base;
               cnt_nx    = CW'(i_k_len);
               if (i_k_len == '0) begin
                  state_nx = S_DONE;
                  done_nx  = 1'b1;
                  err_nx   = 1'b1;
               end else begin
                  state_nx = S_CLEAR;
                  clear_nx = 1'b1;
                  busy_nx  = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            state_nx  = S_FEED;
            busy_nx   = 1'b1;
            rd_en_nx  = 1'b1;
            a_addr_nx = a_base;
            w_addr_nx = w_base;
         end
         S_FEED: begin
            busy_nx = 1'b1;
            if (cnt == CW'(1)) begin
               state_nx = S_DRAIN;
               cnt_nx   = DRAIN_LEN;
            end else begin
               rd_en_nx  = 1'b1;
               cnt_nx    = cnt - CW'(1);
               a_addr_nx = o_a_rd_addr + AW'(1);
               w_addr_nx = o_w_rd_addr + AW'(1);
            end
         end
         S_DRAIN: begin
            busy_nx = 1'b1;
            if (cnt == CW'(1)) begin
               state_nx   = S_CAPTURE;
               capture_nx = 1'b1;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         S_CAPTURE: begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (flush) begin
         state_nx   = S_IDLE;
         busy_nx    = 1'b0;
         done_nx    = 1'b0;
         err_nx     = 1'b0;
         clear_nx   = 1'b0;
         rd_en_nx   = 1'b0;
         capture_nx = 1'b0;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         a_base      <= '0;
         w_base      <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
         o_pe_clear  <= 1'b0;
         o_a_rd_en   <= 1'b0;
         o_w_rd_en   <= 1'b0;
         o_a_rd_addr <= '0;
         o_w_rd_addr <= '0;
         o_capture   <= 1'b0;
         o_row_valid <= '0;
         o_col_valid <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         a_base      <= a_base_nx;
         w_base      <= w_base_nx;
         o_busy      <= busy_nx;
         o_done      <= done_nx;
         o_err       <= err_nx;
         o_pe_clear  <= clear_nx;
         o_a_rd_en   <= rd_en_nx;
         o_w_rd_en   <= rd_en_nx;
         o_a_rd_addr <= a_addr_nx;
         o_w_rd_addr <= w_addr_nx;
         o_capture   <= capture_nx;
         // Read data lands one cycle after the enable; lane r/c adds r/c more cycles of skew.
         if (flush) begin
            o_row_valid <= '0;
            o_col_valid <= '0;
         end else begin
            o_row_valid[0] <= o_a_rd_en;
            for (int r = 1; r < ROWS; r++) o_row_valid[r] <= o_row_valid[r-1];
            o_col_valid[0] <= o_w_rd_en;
            for (int c = 1; c < COLS; c++) o_col_valid[c] <= o_col_valid[c-1];
         end
      end
   end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Bench for systolic_tile_ctrl: a cycle-offset model of each tile is checked against
// every output each cycle, plus hand-computed literal checks at key cycles.
module tb_systolic_tile_ctrl;
   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int KW   = 8;
   localparam int AW   = 10;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [KW-1:0]   k_len = '0;
   logic [AW-1:0]   a_base = '0;
   logic [AW-1:0]   w_base = '0;
   logic            busy, done, err, pe_clear, a_rd_en, w_rd_en, capture;
   logic [AW-1:0]   a_addr, w_addr;
   logic [ROWS-1:0] row_valid;
   logic [COLS-1:0] col_valid;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int t0  = 0;
   int ts  = 0;
   int mk  = 0;
   bit act = 1'b0;
   logic [AW-1:0] ma = '0;
   logic [AW-1:0] mw = '0;
   int m_off, m_last;
   bit m_intile;

   systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .AW(AW)) dut (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
      .i_k_len(k_len), .i_a_base(a_base), .i_w_base(w_base),
      .o_busy(busy), .o_done(done), .o_err(err), .o_pe_clear(pe_clear),
      .o_a_rd_en(a_rd_en), .o_a_rd_addr(a_addr), .o_w_rd_en(w_rd_en), .o_w_rd_addr(w_addr),
      .o_row_valid(row_valid), .o_col_valid(col_valid), .o_capture(capture)
   );

   initial forever #5 clk = ~clk;

   // A tile accepted at edge t0 occupies cycles t0+1 .. t0+last.
   assign m_off    = cyc - t0;
   assign m_last   = (mk == 0) ? 1 : mk + ROWS + COLS + 4;
   assign m_intile = act && (m_off >= 1) && (m_off <= m_last);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (!m_intile) begin
            if (start) begin
               act <= 1'b1;
               t0  <= cyc;
               mk  <= int'(k_len);
               ma  <= a_base;
               mw  <= w_base;
            end
         end else if (abort) begin
            act <= 1'b0;
         end
      end
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   task automatic compare_all();
      int off, k, x;
      logic e_busy, e_done, e_err, e_clr, e_rd, e_cap;
      logic [ROWS-1:0] e_row;
      logic [COLS-1:0] e_col;
      logic [AW-1:0] e_a, e_w;
      off = m_off;
      k = mk;
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_clr = 1'b0; e_rd = 1'b0; e_cap = 1'b0;
      e_row = '0; e_col = '0; e_a = ma; e_w = mw;
      if (m_intile) begin
         e_done = (off == m_last);
         e_err  = (k == 0) && (off == 1);
         if (k > 0) begin
            e_busy = (off <= k + ROWS + COLS + 3);
            e_clr  = (off == 1);
            e_rd   = (off >= 2) && (off <= k + 1);
            e_cap  = (off == k + ROWS + COLS + 3);
            for (int r = 0; r < ROWS; r++) begin
               x = off - 1 - r;
               e_row[r] = (x >= 2) && (x <= k + 1);
            end
            for (int c = 0; c < COLS; c++) begin
               x = off - 1 - c;
               e_col[c] = (x >= 2) && (x <= k + 1);
            end
            e_a = ma + AW'(off - 2);
            e_w = mw + AW'(off - 2);
         end
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("pe_clear", pe_clear, e_clr);
      chk("a_rd_en", a_rd_en, e_rd);
      chk("w_rd_en", w_rd_en, e_rd);
      chk("capture", capture, e_cap);
      chk("row_valid", row_valid, e_row);
      chk("col_valid", col_valid, e_col);
      if (e_rd) begin
         chk("a_rd_addr", a_addr, e_a);
         chk("w_rd_addr", w_addr, e_w);
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_off(int target);
      int guard;
      guard = 0;
      while ((cyc - ts) < target && guard < 1000) begin
         step();
         guard++;
      end
      if ((cyc - ts) != target) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_off: reached offset %0d required %0d", cyc - ts, target);
      end
   endtask

   task automatic start_tile(int k, int a, int w);
      step();
      start  = 1'b1;
      k_len  = KW'(k);
      a_base = AW'(a);
      w_base = AW'(w);
      ts = cyc;
      step();
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_row_valid", row_valid, 0);

      // K=3 reference tile
      start_tile(3, 'h010, 'h200);
      chk("lit_clear_c1", pe_clear, 1);
      wait_off(2);
      chk("lit_a_c2", a_addr, 'h010);
      chk("lit_w_c2", w_addr, 'h200);
      wait_off(3);
      chk("lit_row_c3", row_valid, 4'b0001);
      chk("lit_a_c3", a_addr, 'h011);
      wait_off(4);
      chk("lit_a_c4", a_addr, 'h012);
      chk("lit_w_c4", w_addr, 'h202);
      wait_off(5);
      chk("lit_row_c5", row_valid, 4'b0111);
      chk("lit_rd_c5", a_rd_en, 0);
      wait_off(8);
      chk("lit_row_c8", row_valid, 4'b1000);
      wait_off(9);
      chk("lit_row_c9", row_valid, 4'b0000);
      wait_off(13);
      chk("lit_cap_c13", capture, 0);
      wait_off(14);
      chk("lit_cap_c14", capture, 1);
      wait_off(15);
      chk("lit_done_c15", done, 1);
      chk("lit_busy_c15", busy, 0);
      wait_off(17);

      // K=0 error path
      start_tile(0, 'h005, 'h006);
      chk("lit_k0_done", done, 1);
      chk("lit_k0_err", err, 1);
      chk("lit_k0_busy", busy, 0);
      wait_off(4);

      // address wrap
      start_tile(4, 'h3FE, 'h001);
      wait_off(2);
      chk("lit_wrap_c2", a_addr, 'h3FE);
      wait_off(3);
      chk("lit_wrap_c3", a_addr, 'h3FF);
      wait_off(4);
      chk("lit_wrap_c4", a_addr, 'h000);
      wait_off(5);
      chk("lit_wrap_c5", a_addr, 'h001);
      wait_off(18);

      // start held high: back-to-back tiles; later pulses are ignored
      step();
      start = 1'b1; k_len = 8'd3; a_base = 'h100; w_base = 'h180;
      ts = cyc;
      wait_off(1);
      chk("lit_hold_clear1", pe_clear, 1);
      wait_off(16);
      chk("lit_hold_idle", busy, 0);
      wait_off(17);
      chk("lit_hold_clear2", pe_clear, 1);
      wait_off(18);
      start = 1'b0;
      wait_off(20);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_off(25);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_off(35);
      chk("lit_no_extra", busy, 0);
      wait_off(40);

      // abort in FEED
      start_tile(3, 'h020, 'h220);
      wait_off(3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("lit_abort_busy", busy, 0);
      chk("lit_abort_row", row_valid, 0);
      chk("lit_abort_rd", a_rd_en, 0);
      wait_off(20);

      // abort with start in IDLE: start wins
      step();
      start = 1'b1; abort = 1'b1; k_len = 8'd1; a_base = 'h030; w_base = 'h230;
      ts = cyc;
      step();
      start = 1'b0; abort = 1'b0;
      chk("lit_abort_idle_clear", pe_clear, 1);
      wait_off(15);

      // maximum K
      start_tile(255, 'h3F0, 'h000);
      wait_off(256);
      chk("lit_kmax_rd", a_rd_en, 1);
      chk("lit_kmax_addr", a_addr, 'h0EE);
      wait_off(257);
      chk("lit_kmax_rd_off", a_rd_en, 0);
      wait_off(267);
      chk("lit_kmax_done", done, 1);
      wait_off(269);

      // asynchronous reset in DRAIN, then a fresh tile
      start_tile(3, 'h040, 'h240);
      wait_off(8);
      #2 rst_n = 1'b0;
      #1;
      chk("lit_arst_busy", busy, 0);
      chk("lit_arst_row", row_valid, 0);
      chk("lit_arst_addr", a_addr, 0);
      step();
      step();
      rst_n = 1'b1;
      start_tile(2, 'h050, 'h250);
      chk("lit_post_rst_clear", pe_clear, 1);
      wait_off(2);
      chk("lit_post_rst_addr", a_addr, 'h050);
      wait_off(16);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/systolic_tile_ctrl.md
Name: systolic_tile_ctrl

Overview:
- Sequencer for a ROWS x COLS output-stationary array of 8-bit MAC PEs (input-registered multiply-accumulate cells).
- One tile per start: clears PE accumulators, streams K activation/weight vectors from two single-port read memories with per-row/per-column skew valids, waits for the array to drain, then pulses capture and done.
- Sits between the host command interface and the array/memories. It does not touch datapath values.

Parameters:
- ROWS, 4, PE array rows (activation lanes), >=1
- COLS, 4, PE array columns (weight lanes), >=1
- KW, 8, width of tile depth K
- AW, 10, memory address width

Ports:
- i_clock  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  tile request; sampled only in IDLE
- i_abort  in  1  synchronous abort; effective in any non-IDLE state
- i_k_len  in  KW  tile depth K; latched on accepted start
- i_a_base  in  AW  activation memory base address; latched on start
- i_w_base  in  AW  weight memory base address; latched on start
- o_busy  out  1  high in CLEAR, FEED, DRAIN, CAPTURE
- o_done  out  1  one-cycle pulse at tile completion
- o_err  out  1  one-cycle pulse, coincident with o_done, when K==0
- o_pe_clear  out  1  one-cycle accumulator clear pulse to array
- o_a_rd_en  out  1  activation memory read enable
- o_a_rd_addr  out  AW  activation read address
- o_w_rd_en  out  1  weight memory read enable
- o_w_rd_addr  out  AW  weight read address
- o_row_valid  out  ROWS  bit r: activation lane r carries valid data
- o_col_valid  out  COLS  bit c: weight lane c carries valid data
- o_capture  out  1  one-cycle pulse; array outputs final

Behaviour:
- Clock and reset: one clock, i_clock; asynchronous active-low reset i_reset_n.
- Reset: every output 0 and state IDLE. This holds even mid-tile. Skew shift registers, counters and latched K/bases are all cleared.
- All outputs are registered.
- States and cycle numbering (start sampled at edge 0):
  - IDLE: on i_start=1 latch K and bases.
    - If K==0, go to DONE with o_err set.
    - Otherwise go to CLEAR.
  - CLEAR (cycle 1): o_pe_clear=1, o_busy=1.
  - FEED (cycles 2..K+1): o_a_rd_en=o_w_rd_en=1.
    - o_a_rd_addr = a_base + step and o_w_rd_addr = w_base + step, for step = 0..K-1.
    - Addition is modulo 2^AW (wrap, no error).
  - DRAIN: exactly ROWS+COLS+1 cycles; read enables 0, addresses hold last value.
  - CAPTURE: one cycle, o_capture=1.
  - DONE: one cycle, o_done=1, o_busy=0; then IDLE.
- Total latency start-edge to o_done cycle = K + ROWS + COLS + 4.
- Skew valids: feed_v = 1 in FEED cycles. Memory read latency is 1 cycle.
  - o_row_valid[r] = feed_v delayed 1+r cycles.
  - o_col_valid[c] = feed_v delayed 1+c cycles.
  - Shifting continues through DRAIN, so all bits are 0 before CAPTURE.
- i_start in any state other than IDLE is ignored. No queueing.
- A start held high continuously restarts at the first IDLE cycle after DONE.
- i_abort=1 in a non-IDLE state:
  - next cycle is IDLE;
  - all valids, read enables and pulses are 0;
  - no o_done or o_capture.
- i_abort in IDLE is ignored. i_abort and i_start together in IDLE: start wins.
- K==0 path:
  - cycle 1 is DONE with o_done=o_err=1;
  - no clear, no reads, no capture, o_busy never asserts.
- K = 2^KW-1 is supported; the step counter must not overflow.

Test Plan:
- Reset asserted mid-DRAIN -> all outputs 0 asynchronously; after release, o_busy=0 and the next start runs a full tile from CLEAR.
- ROWS=COLS=4, K=3, a_base=0x010, w_base=0x200:
  - o_pe_clear in cycle 1;
  - reads 0x010/0x200, 0x011/0x201, 0x012/0x202 in cycles 2-4;
  - o_row_valid[0] high in cycles 3-5, o_row_valid[3] high in cycles 6-8;
  - o_capture in cycle 14, o_done in cycle 15.
- K=0 -> o_done=o_err=1 in cycle 1; o_busy, o_pe_clear, rd_en and o_capture stay 0.
- a_base=0x3FE, K=4, AW=10 -> activation addresses 0x3FE, 0x3FF, 0x000, 0x001.
- i_start held high with K=3 -> second o_pe_clear in cycle 17; starts pulsed during FEED/DRAIN produce no extra tile.
- i_abort in cycle 3 (FEED, step 1) -> cycle 4 is IDLE with all valids 0, o_busy=0, and no o_capture/o_done ever follows.
